instr_fetch: RTL

Instruction fetch stage for the single-cycle RISC-V core. It sits directly upstream of the instruction ROM and drives its word-aligned byte address from an internal program counter. It captures the ROM's combinational instruction word into a 2-entry fetch buffer, and presents {pc, instruction} to decode with a valid/ready handshake. It also handles branch/jump redirects and halts on misaligned or out-of-range fetch addresses.

---
 rtl/instr_fetch.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch stage. Drives a word-aligned byte address to a
//            combinational instruction ROM from an internal program counter,
//            captures {pc, instruction} into a 2-entry FIFO and presents the
//            head to decode over a valid/ready handshake. Handles branch/jump
//            redirects and halts on misaligned or out-of-range fetch targets.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            rom_addr / rom_data - ROM byte address out, instruction word in
//            redirect_valid/_pc  - taken branch/jump and its target
//            out_valid/_ready    - decode handshake
//            out_instr / out_pc  - instruction at buffer head and its address
//            fault / fault_code  - HALT indicator, 01 misaligned, 10 range
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int               WIDTH     = 32,
    parameter int               ROM_DEPTH = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    output logic             fault,
    output logic [1:0]       fault_code
);

    // First byte address past the end of the ROM.
    localparam logic [WIDTH-1:0] c_rom_bytes   = WIDTH'(ROM_DEPTH * 4);
    localparam logic [WIDTH-1:0] c_pc_step     = WIDTH'(4);
    localparam logic [1:0]       c_fc_none     = 2'b00;
    localparam logic [1:0]       c_fc_misalign = 2'b01;
    localparam logic [1:0]       c_fc_range    = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           r_state_q, w_state_d;
    logic [WIDTH-1:0] r_pc_q, w_pc_d;
    logic [1:0]       r_count_q, w_count_d;
    logic [1:0]       r_fc_q, w_fc_d;
    logic [WIDTH-1:0] r_head_pc_q, w_head_pc_d;
    logic [WIDTH-1:0] r_head_instr_q, w_head_instr_d;
    logic [WIDTH-1:0] r_tail_pc_q, w_tail_pc_d;
    logic [WIDTH-1:0] r_tail_instr_q, w_tail_instr_d;

    logic             w_pop;
    logic             w_push;
    logic [WIDTH-1:0] w_pc_inc;

    assign w_pop    = (r_count_q != 2'd0) && out_ready;
    assign w_pc_inc = r_pc_q + c_pc_step;

    always_comb begin
        w_state_d      = r_state_q;
        w_pc_d         = r_pc_q;
        w_count_d      = r_count_q;
        w_fc_d         = r_fc_q;
        w_head_pc_d    = r_head_pc_q;
        w_head_instr_d = r_head_instr_q;
        w_tail_pc_d    = r_tail_pc_q;
        w_tail_instr_d = r_tail_instr_q;
        w_push         = 1'b0;

        if (redirect_valid) begin
            // Flush: a same-cycle pop still completes for decode, but every
            // buffered entry is now on the wrong path.
            w_count_d = 2'd0;
            if (redirect_pc[1:0] != 2'b00) begin
                w_state_d = ST_HALT;
                w_fc_d    = c_fc_misalign;
            end else if (redirect_pc >= c_rom_bytes) begin
                w_state_d = ST_HALT;
                w_fc_d    = c_fc_range;
            end else begin
                w_pc_d    = redirect_pc;
                w_state_d = ST_RUN;
                w_fc_d    = c_fc_none;
            end
        end else begin
            w_push = (r_state_q == ST_RUN) && ((r_count_q < 2'd2) || w_pop);

            if (w_push) begin
                // The last ROM word is fetched normally; the pc then parks on
                // it rather than stepping past the end.
                if (w_pc_inc == c_rom_bytes) begin
                    w_state_d = ST_HALT;
                    w_fc_d    = c_fc_range;
                end else begin
                    w_pc_d = w_pc_inc;
                end
            end

            unique case ({w_push, w_pop})
                2'b11: begin
                    if (r_count_q == 2'd2) begin
                        w_head_pc_d    = r_tail_pc_q;
                        w_head_instr_d = r_tail_instr_q;
                        w_tail_pc_d    = r_pc_q;
                        w_tail_instr_d = rom_data;
                    end else begin
                        w_head_pc_d    = r_pc_q;
                        w_head_instr_d = rom_data;
                    end
                end
                2'b10: begin
                    if (r_count_q == 2'd0) begin
                        w_head_pc_d    = r_pc_q;
                        w_head_instr_d = rom_data;
                    end else begin
                        w_tail_pc_d    = r_pc_q;
                        w_tail_instr_d = rom_data;
                    end
                    w_count_d = r_count_q + 2'd1;
                end
                2'b01: begin
                    w_head_pc_d    = r_tail_pc_q;
                    w_head_instr_d = r_tail_instr_q;
                    w_count_d      = r_count_q - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q      <= ST_RUN;
            r_pc_q         <= RESET_PC;
            r_count_q      <= 2'd0;
            r_fc_q         <= c_fc_none;
            r_head_pc_q    <= '0;
            r_head_instr_q <= '0;
            r_tail_pc_q    <= '0;
            r_tail_instr_q <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_pc_q         <= w_pc_d;
            r_count_q      <= w_count_d;
            r_fc_q         <= w_fc_d;
            r_head_pc_q    <= w_head_pc_d;
            r_head_instr_q <= w_head_instr_d;
            r_tail_pc_q    <= w_tail_pc_d;
            r_tail_instr_q <= w_tail_instr_d;
        end
    end

    assign rom_addr   = r_pc_q;
    assign out_valid  = (r_count_q != 2'd0);
    assign out_instr  = r_head_instr_q;
    assign out_pc     = r_head_pc_q;
    assign fault      = (r_state_q == ST_HALT);
    assign fault_code = r_fc_q;

endmodule
`default_nettype wire
